mult_div_unit: RTL and testbench

- Parametrised multi-cycle HI/LO multiply/divide unit for the MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO and owns the HI and LO registers.
- Replaces single-cycle in-core HI/LO arithmetic with an iterative engine: one result bit per cycle, with a busy handshake the core uses to stall.
- Sits beside the ALU. Operands come from the register-file read ports; `hi`/`lo` feed the MFHI/MFLO write-back mux.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/md_unsigned_core.sv | 80 ++++++++
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared encodings for the HI/LO multiply/divide unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } t_md_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } t_md_state;

endpackage

`default_nettype wire

// File: rtl/md_unsigned_core.sv
// ============================================================================
// md_unsigned_core : iterative unsigned shift-add multiply / restoring divide
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unsigned_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand_b;
    logic             div_mode;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // acc_lo holds the multiplier (consumed LSB first) or the dividend
    // (consumed MSB first, quotient bits shifted in behind it).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, operand_b});
        div_diff  = div_shift[WIDTH-1:0] - operand_b;
        if (div_mode) begin
            nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            div_mode  <= 1'b0;
            count     <= '0;
        end else if (load) begin
            acc_hi    <= '0;
            acc_lo    <= op_a;
            operand_b <= op_b;
            div_mode  <= is_div;
            count     <= '0;
        end else if (step) begin
            acc_hi    <= nxt_hi;
            acc_lo    <= nxt_lo;
            count     <= count + CNT_W'(1);
        end
    end

    assign last   = (count == CNT_W'(WIDTH-1));
    assign res_lo = acc_lo;
    assign res_hi = acc_hi;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : multi-cycle HI/LO multiply/divide unit owning HI and LO
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clock_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    t_md_state state;
    t_md_state state_nxt;

    logic             accept_iter;
    logic             accept_mthi;
    logic             accept_mtlo;
    logic             signed_op;
    logic             is_div;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;

    logic             sign_res;
    logic             sign_dvd;
    logic             div_op;
    logic             div_zero;

    logic             core_last;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] core_hi;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        accept_iter = 1'b0;
        accept_mthi = 1'b0;
        accept_mtlo = 1'b0;
        signed_op   = 1'b0;
        if ((state == IDLE) && start) begin
            case (op)
                MD_MULT, MD_DIV: begin
                    accept_iter = 1'b1;
                    signed_op   = 1'b1;
                end
                MD_MULTU, MD_DIVU: accept_iter = 1'b1;
                MD_MTHI:           accept_mthi = 1'b1;
                MD_MTLO:           accept_mtlo = 1'b1;
                default: ;
            endcase
        end
    end

    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign rs_abs = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_abs = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_iter) state_nxt = RUN;
            RUN:     if (core_last)   state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (clock_enable) begin
            state <= state_nxt;
        end
    end

    assign busy = (state != IDLE);

    md_unsigned_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (clock_enable && accept_iter),
        .step    (clock_enable && (state == RUN)),
        .is_div  (is_div),
        .op_a    (rs_abs),
        .op_b    (rt_abs),
        .last    (core_last),
        .res_lo  (core_lo),
        .res_hi  (core_hi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_res <= 1'b0;
            sign_dvd <= 1'b0;
            div_op   <= 1'b0;
            div_zero <= 1'b0;
        end else if (clock_enable && accept_iter) begin
            sign_res <= signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            sign_dvd <= signed_op && rs_val[WIDTH-1];
            div_op   <= is_div;
            div_zero <= is_div && (rt_val == '0);
        end
    end

    // With a zero divisor the core leaves |rs| in the remainder, so the
    // dividend-sign correction restores the original rs_val for HI.
    always_comb begin
        prod_fix = sign_res ? -{core_hi, core_lo} : {core_hi, core_lo};
        quot_fix = div_zero ? {WIDTH{1'b1}} : (sign_res ? -core_lo : core_lo);
        rem_fix  = sign_dvd ? -core_hi : core_hi;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (clock_enable) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (state == FIX) begin
                if (div_op) begin
                    hi          <= rem_fix;
                    lo          <= quot_fix;
                    div_by_zero <= div_zero;
                end else begin
                    {hi, lo}    <= prod_fix;
                end
                done <= 1'b1;
            end
            if (accept_mthi) begin
                hi   <= rs_val;
                done <= 1'b1;
            end
            if (accept_mtlo) begin
                lo   <= rs_val;
                done <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit : self-checking bench for mult_div_unit (WIDTH=32)
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clock_enable;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clock_enable (clock_enable),
        .start        (start),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero),
        .hi           (hi),
        .lo           (lo)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;
    logic mon_ce;
    exp_t mon_e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: one result per enabled edge that shows done.
    initial begin
        forever begin
            @(posedge clk);
            mon_ce = clock_enable;
            #1;
            if (div_by_zero && !done)
                check("dbz_without_done", {63'd0, div_by_zero}, 64'd0);
            if (done && mon_ce && reset_n) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
                    check("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
                    check("result_dbz", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
                    prev_done_cyc = last_done_cyc;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit push);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (push) sb.push_back(e);
        step();
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sd;
        logic signed [2*W-1:0] pa;
        logic signed [2*W-1:0] pb;
        logic [2*W-1:0]        p;
        sa = a;
        sd = b;
        pa = sa;
        pb = sd;
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            3'd0: begin p = pa * pb; {e.hi, e.lo} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = p; end
            3'd2: begin e.lo = sa / sd; e.hi = sa % sd; end
            default: begin e.lo = a / b; e.hi = a % b; end
        endcase
        return e;
    endfunction

    vec_t vecs[10];

    initial begin
        int   n;
        exp_t e;
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[5] = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[6] = '{3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{3'd3, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0};
        vecs[8] = '{3'd4, 32'h1234,     32'hAAAA,     32'h1234,     32'd3,        1'b0};
        vecs[9] = '{3'd5, 32'h5678,     32'hBBBB,     32'h1234,     32'h5678,     1'b0};

        reset_n      = 1'b0;
        clock_enable = 1'b1;
        start        = 1'b0;
        op           = 3'd0;
        rs_val       = '0;
        rt_val       = '0;
        repeat (3) step();
        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
        reset_n = 1'b1;
        step();

        // MULTU max x max: latency and HI/LO stability during RUN
        e = '{32'hFFFFFFFE, 32'h00000001, 1'b0};
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, e, 1'b1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 16) begin
                check("run_hi_stable", {32'd0, hi}, 64'd0);
                check("run_lo_stable", {32'd0, lo}, 64'd0);
            end
            step();
        end
        check("multu_busy_cycles", 64'(n), 64'd33);
        check("done_now", {63'd0, done}, 64'd1);
        step();
        check("done_single_pulse", {63'd0, done}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            e = '{vecs[i].hi, vecs[i].lo, vecs[i].dbz};
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, e, 1'b1);
            if (vecs[i].op >= 3'd4) check("mt_no_busy", {63'd0, busy}, 64'd0);
            wait_idle();
        end
        repeat (2) step();

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (ro >= 3'd2) rb = rb >> $urandom_range(0, 28);
            if (rb == '0) rb = 32'd1;
            if (ro == 3'd2 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) ra = 32'd1;
            issue(ro, ra, rb, model(ro, ra, rb), 1'b1);
            wait_idle();
        end

        // back-to-back throughput
        issue(3'd1, 32'd11, 32'd13, model(3'd1, 32'd11, 32'd13), 1'b1);
        wait_idle();
        issue(3'd2, 32'hFFFFFF00, 32'd9, model(3'd2, 32'hFFFFFF00, 32'd9), 1'b1);
        wait_idle();
        step();
        check("back_to_back_period", 64'(last_done_cyc - prev_done_cyc), 64'd34);
        step();

        // start while busy (and op 6) ignored
        e = '{32'd0, 32'd15, 1'b0};
        issue(3'd1, 32'd3, 32'd5, e, 1'b1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 5) begin start = 1'b1; op = 3'd1; rs_val = 32'd100; rt_val = 32'd100; end
            if (n == 7) op = 3'd6;
            if (n == 9) start = 1'b0;
            step();
        end
        check("busy_ignore_cycles", 64'(n), 64'd33);
        repeat (2) step();
        start = 1'b1; op = 3'd6; rs_val = 32'hDEADBEEF;
        step();
        start = 1'b0;
        check("op6_no_busy", {63'd0, busy}, 64'd0);
        step();
        check("op6_no_done", {63'd0, done}, 64'd0);
        check("op6_hi_kept", {32'd0, hi}, 64'd0);
        check("op6_lo_kept", {32'd0, lo}, 64'd15);

        // clock_enable low for 5 cycles mid-RUN
        issue(3'd1, 32'h1234, 32'h10, model(3'd1, 32'h1234, 32'h10), 1'b1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 10) clock_enable = 1'b0;
            if (n == 15) clock_enable = 1'b1;
            step();
        end
        check("ce_busy_cycles", 64'(n), 64'd38);
        clock_enable = 1'b0;
        step();
        check("ce_done_held", {63'd0, done}, 64'd1);
        clock_enable = 1'b1;
        step();
        check("ce_done_cleared", {63'd0, done}, 64'd0);

        // reset 10 cycles into a DIV
        issue(3'd2, 32'hFFFFFF9C, 32'd7, model(3'd2, 32'hFFFFFF9C, 32'd7), 1'b1);
        repeat (9) step();
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hi",   {32'd0, hi}, 64'd0);
        check("rst_mid_lo",   {32'd0, lo}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        e = sb.pop_back();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (40) step();
        e = '{32'd0, 32'd42, 1'b0};
        issue(3'd1, 32'd6, 32'd7, e, 1'b1);
        wait_idle();
        step();

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
